mdu: RTL
========

# mdu

Iterative multiply/divide unit, `WIDTH`-parametrised, implementing the RISC-V M-extension operations alongside the single-cycle `alu`. It sits in the execute stage. Operands come in under a start/busy/valid handshake, and the result is produced after a fixed radix-2 iteration count. Divide-by-zero and signed overflow take a one-cycle fast path. A kill input discards in-flight work on pipeline flush.

## Interface
- `WIDTH`, 32: operand/result width; even, ≥ 4.
- `clk_i`  in  1  clock; all state changes on rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `start_i`  in  1  request; accepted only in IDLE.
- `op_i`  in  3  operation (funct3): MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.
- `in0_i`  in  WIDTH  rs1 operand (dividend / multiplicand).
- `in1_i`  in  WIDTH  rs2 operand (divisor / multiplier).
- `kill_i`  in  1  abort current operation.
- `busy_o`  out  1  high whenever state ≠ IDLE.
- `valid_o`  out  1  one-cycle pulse; `result_o` is valid.
- `result_o`  out  WIDTH  result; held until the next accepted result.

## Operation
- Three states: IDLE, CALC, DONE.
- IDLE → CALC on `start_i & ~kill_i`.
- IDLE → DONE on the same condition when the fast path applies.
- CALC → DONE when the iteration counter reaches `WIDTH`.
- DONE → IDLE unconditionally.
- Any state → IDLE on `kill_i`.
- On accept, latch op, signedness flags, magnitude operands and result sign.
- Signed operands are converted to absolute value for MULH/DIV/REM (rs1 and rs2) and MULHSU (rs1 only). Sign is latched as rs1_sign^rs2_sign for MUL*/DIV, and rs1_sign for REM.
- Multiply: 2·`WIDTH` shift-add accumulator, one multiplier bit per CALC cycle.
  - MUL returns the low half.
  - MULH/MULHSU/MULHU return the high half of the sign-corrected 2·`WIDTH` product.
- Divide: restoring, one quotient bit per CALC cycle. Partial remainder is `WIDTH`+1 bits. DIV/DIVU return the quotient; REM/REMU return the remainder. The result is negated if the latched sign is set.
- Fast path, decided at accept and never iterated:
  - Divisor = 0: DIV/DIVU return all ones; REM/REMU return `in0_i`.
  - Signed overflow (`in0_i` = most-negative, `in1_i` = −1): DIV returns most-negative; REM returns 0.
- MUL with a zero operand is not special-cased; it iterates normally.
- All arithmetic wraps modulo 2^`WIDTH` (or 2^(2·`WIDTH`) for the product); no saturation.

## Timing
- Reset values: state IDLE; `busy_o` = 0, `valid_o` = 0, `result_o` = 0; all internal registers cleared.
- Accept edge is cycle 0.
- Normal latency: CALC occupies cycles 1..`WIDTH`; DONE is cycle `WIDTH`+1.
- `valid_o` = (state == DONE); `result_o` is registered on entry to DONE.
- Fast-path latency: `valid_o` in cycle 1.
- Throughput: one operation per `WIDTH`+2 cycles. `start_i` in DONE is ignored; the next accept is possible in the IDLE cycle after DONE.
- `start_i` while busy is ignored, with no queueing.
- Operands are sampled only at accept; input changes afterwards have no effect.
- `kill_i` wins over `start_i` in the same cycle.
- `kill_i` in DONE: `valid_o` still pulses that cycle, because it is combinational from state. The state then returns to IDLE.
- `kill_i` in CALC: IDLE next cycle, no `valid_o`, `result_o` unchanged.
- Reset mid-operation: IDLE next edge, no `valid_o`.

## Structure
- Shared package `mdu_pkg` holds the op encodings, the state enum, and helper functions `is_div(op)`, `is_signed_a(op)`, `is_signed_b(op)`, `is_high(op)`.
- Single module; no sub-module.
- One counter of `$clog2(WIDTH+1)` bits.
- One 2·`WIDTH` shift register, shared between the product accumulator and the remainder/quotient pair.

## Test plan
- MUL 7×−3 → `valid_o` at cycle 33, `result_o` = 0xFFFF_FFEB; `busy_o` high for cycles 1–33.
- MULH 0x8000_0000×0x8000_0000 → 0x4000_0000; MULHU 0xFFFF_FFFF×0xFFFF_FFFF → 0xFFFF_FFFE; MULHSU −1×0xFFFF_FFFF → 0xFFFF_FFFF.
- DIV −7/2 → −3 (0xFFFF_FFFD); REM −7/2 → −1; DIVU 100/7 → 14; REMU 100/7 → 2; each `valid_o` at cycle 33.
- DIV x/0 → 0xFFFF_FFFF at cycle 1; REM 0x1234/0 → 0x1234; DIV 0x8000_0000/−1 → 0x8000_0000 and REM → 0, both at cycle 1.
- Handshake and flush:
  - `start_i` held during CALC → only one `valid_o`.
  - `kill_i` at cycle 10 → IDLE at cycle 11, no `valid_o`, `result_o` retains its previous value.
  - `start_i` and `kill_i` together in IDLE → no accept.
- `rst_ni` = 0 at cycle 5 of an operation → all outputs 0 next edge. Repeat a random-operand sweep at `WIDTH` = 8 against a reference model, exhaustive over all operand pairs.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM states and op-decode helpers for the multiply/divide unit
package mdu_pkg;
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] op);
    return op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM;
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return op == OP_MULH || op == OP_DIV || op == OP_REM;
  endfunction

  function automatic logic is_high(input logic [2:0] op);
    return ~op[2] & (op[1:0] != 2'b00);
  endfunction
endpackage

// File: rtl/mdu.sv
// mdu: iterative radix-2 multiply/divide unit for the RISC-V M extension
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] in0_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic             kill_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_t             state;
  logic [2:0]         op;
  logic               neg;
  logic [WIDTH-1:0]   m;
  logic [2*WIDTH-1:0] sr;
  logic [CW-1:0]      cnt;

  logic               sa, sb, sign_in, div0, ovf, fast;
  logic [WIDTH-1:0]   abs_a, abs_b, fast_res, quo_rem, calc_res;
  logic [WIDTH:0]     sum, rem_sh, diff;
  logic [2*WIDTH-1:0] sr_n, prod;
  logic [CW-1:0]      cnt_n;

  // accept-time decode: magnitudes, result sign and the divide fast path
  always_comb begin
    sa       = is_signed_a(op_i) & in0_i[WIDTH-1];
    sb       = is_signed_b(op_i) & in1_i[WIDTH-1];
    abs_a    = sa ? -in0_i : in0_i;
    abs_b    = sb ? -in1_i : in1_i;
    sign_in  = is_rem(op_i) ? sa : sa ^ sb;
    div0     = is_div(op_i) && in1_i == '0;
    ovf      = is_div(op_i) && is_signed_b(op_i) && in0_i == {1'b1, {(WIDTH-1){1'b0}}} && &in1_i;
    fast     = div0 | ovf;
    fast_res = div0 ? (is_rem(op_i) ? in0_i : '1) : (is_rem(op_i) ? '0 : in0_i);
  end

  // one shift-add or restoring-divide step on the shared register, plus final sign fix-up
  always_comb begin
    sum      = {1'b0, sr[2*WIDTH-1:WIDTH]} + {1'b0, m & {WIDTH{sr[0]}}};
    rem_sh   = sr[2*WIDTH-1:WIDTH-1];
    diff     = rem_sh - {1'b0, m};
    sr_n     = is_div(op) ? {diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0], sr[WIDTH-2:0], ~diff[WIDTH]}
                          : {sum, sr[WIDTH-1:1]};
    prod     = neg ? -sr_n : sr_n;
    quo_rem  = is_rem(op) ? sr_n[2*WIDTH-1:WIDTH] : sr_n[WIDTH-1:0];
    calc_res = is_div(op) ? (neg ? -quo_rem : quo_rem)
                          : (is_high(op) ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0]);
    cnt_n    = cnt + 1'b1;
  end

  // control FSM with operand latching and registered result
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= IDLE;
      op       <= '0;
      neg      <= 1'b0;
      m        <= '0;
      sr       <= '0;
      cnt      <= '0;
      result_o <= '0;
    end else if (kill_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          op    <= op_i;
          neg   <= sign_in;
          m     <= is_div(op_i) ? abs_b : abs_a;
          sr    <= {{WIDTH{1'b0}}, is_div(op_i) ? abs_a : abs_b};
          cnt   <= '0;
          state <= fast ? DONE : CALC;
          if (fast) result_o <= fast_res;
        end
        CALC: begin
          sr  <= sr_n;
          cnt <= cnt_n;
          if (cnt_n == LAST) begin
            result_o <= calc_res;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o  = state != IDLE;
  assign valid_o = state == DONE;
endmodule
